mux32_rr_scheduler: RTL and testbench
=====================================

// Module: mux32_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 32:1 bit-select mux between K requesters.
//  Picks the next requesting input, drives the mux select, and holds it stable for a
//  burst of up to BURST beats under a valid/ready handshake with the downstream consumer.
//  Sits directly in front of the mux_32x1 datapath. Its sel output is that mux's select.
// PARAMETERS
//  K       32  number of requesters / mux inputs (2..32)
//  SEL_W   5   select width, = clog2(K)
//  BURST   4   max handshaked beats granted per requester before rotating (1..16)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      1 = new arbitration allowed; 0 = finish current burst, then idle
//  req        in   K      per-requester request, level sensitive
//  out_ready  in   1      consumer accepts current beat
//  out_valid  out  1      sel/grant valid, beat offered to consumer
//  sel        out  SEL_W  select index to the 32:1 mux
//  grant      out  K      one-hot of sel, qualified by out_valid (all-zero when idle)
//  last       out  1      current beat is the final beat of this burst
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: out_valid=0, sel=0, grant=0, last=0, busy=0, state=IDLE, ptr=0, beat_cnt=0.
//  ptr = highest-priority index. Search order is ptr, ptr+1 .. K-1, 0 .. ptr-1 (wraps).
//  States: IDLE, GRANT.
//  IDLE: if en && |req, register winner into sel, set grant. Go to GRANT, beat_cnt=0.
//        Latency is 1 cycle from req to out_valid=1.
//  GRANT: out_valid=1. sel/grant held stable until out_ready=1 (no change while stalled).
//    On a handshake (out_valid && out_ready):
//    - release if beat_cnt==BURST-1, or req[sel]==0, or en==0. Else beat_cnt++ and stay.
//    - on release, ptr = sel+1, wrapping to 0 at K-1.
//    - if en, and a request is pending under the new ptr, load that winner in the same
//      edge. Stay in GRANT with beat_cnt=0, no idle bubble.
//    - if no request is pending, go to IDLE (out_valid=0 next cycle).
//  A req[sel] drop while stalled is ignored until the handshake. The offered beat always completes.
//  last = out_valid && (beat_cnt==BURST-1 || req[sel]==0 || en==0). Combinational from regs/inputs.
//  Only the granted requester is released, so a single requester may win repeatedly.
//    Other requesters are never starved: each waits at most (K-1) bursts.
//  BURST=1 gives pure per-beat round robin.
//  Indices >= K are never selected. sel is always < K.
//  rst_n asserted mid-burst: all outputs clear immediately (async). The beat is dropped.
//  en deassert in IDLE: no grant. In GRANT: current beat completes, then release.
// STRUCTURE
//  Package mux_sched_pkg holds:
//    state enum {IDLE, GRANT};
//    localparam K_MAX=32;
//    function clog2.
//  Sub-module rr_pick #(K): combinational rotate-priority encoder.
//    Inputs: req, ptr. Outputs: found, idx.
//    Implementation: double-width mask trick, no loops over a case on a loop variable.
//  Top level holds only the FSM, beat counter, ptr and output registers.
// TESTING
//  1. Reset with req=0 -> out_valid=0, sel=0, grant=0, busy=0 for 5 cycles.
//  2. req=32'h0000_0001, out_ready=1, BURST=4 -> 4 beats sel=0, last on beat 4.
//     Then sel=0 re-granted next cycle with no bubble.
//  3. req=32'h8000_0011, out_ready=1, BURST=1 -> sel sequence 0,4,31,0,4,31.
//     grant one-hot matches each sel.
//  4. Stall: grant sel=5, hold out_ready=0 for 6 cycles while dropping req[5].
//     -> sel stays 5, out_valid stays 1. Handshake when out_ready=1, then IDLE.
//  5. Burst at sel=3 beat 2, pulse rst_n=0 between clock edges.
//     -> out_valid/grant drop immediately. After release: ptr=0, first grant is lowest set req.
//  6. en=0 mid-burst at sel=7 -> current beat completes with last=1. No further grant.
//     en=1 again -> grant to next index after 7.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared state encoding, limits and width helper for the 32:1 mux scheduler
package mux_sched_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int K_MAX = 32;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority encoder, first set req at or after ptr (wrapping)
//   req   in  K      request vector
//   ptr   in  SEL_W  highest-priority index
//   found out 1      any request set
//   idx   out SEL_W  winning index, always < K
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int K     = 32,
    parameter int SEL_W = clog2(K)
) (
    input  logic [K-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] KW = (SEL_W + 1)'(K);

    logic [K-1:0]     rot;
    logic [K-1:0]     low;
    logic [SEL_W-1:0] pos;
    logic [SEL_W:0]   sum;

    // Doubling req lets a plain right shift rotate ptr down to bit 0.
    assign rot   = K'({req, req} >> ptr);
    assign low   = rot & (~rot + 1'b1);
    assign found = |req;

    always_comb begin
        pos = '0;
        for (int i = 0; i < K; i++) pos = pos | (low[i] ? SEL_W'(i) : '0);
    end

    // Undo the rotation: position in rotated space plus ptr, modulo K.
    assign sum = {1'b0, pos} + {1'b0, ptr};
    assign idx = SEL_W'(sum >= KW ? sum - KW : sum);

endmodule

// File: rtl/mux32_rr_scheduler.sv
// mux32_rr_scheduler: round-robin burst scheduler driving the select of a 32:1 mux
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   en        in  1      allow new arbitration
//   req       in  K      level-sensitive requests
//   out_ready in  1      consumer accepts current beat
//   out_valid out 1      beat offered, sel/grant valid
//   sel       out SEL_W  mux select
//   grant     out K      one-hot of sel while out_valid
//   last      out 1      final beat of current burst
//   busy      out 1      FSM not idle
module mux32_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int K     = 32,
    parameter int SEL_W = clog2(K),
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [K-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic [K-1:0]     grant,
    output logic             last,
    output logic             busy
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] nxt;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] idx;
    logic [3:0]       beat_cnt;
    logic             found;
    logic             rel;

    assign nxt      = (sel == SEL_W'(K - 1)) ? '0 : sel + 1'b1;
    // In GRANT the next winner is searched from the post-release pointer so it can load on the same edge.
    assign pick_ptr = (state == GRANT) ? nxt : ptr;
    assign rel      = beat_cnt == LAST_BEAT || !req[sel] || !en;
    assign last     = out_valid && rel;
    assign busy     = state != IDLE;

    rr_pick #(.K(K), .SEL_W(SEL_W)) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .found(found),
        .idx  (idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sel       <= '0;
            grant     <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
        end else if (state == IDLE) begin
            if (en && found) begin
                state     <= GRANT;
                out_valid <= 1'b1;
                sel       <= idx;
                grant     <= {{(K-1){1'b0}}, 1'b1} << idx;
                beat_cnt  <= '0;
            end
        end else if (out_ready) begin
            if (!rel) begin
                beat_cnt <= beat_cnt + 1'b1;
            end else begin
                ptr      <= nxt;
                beat_cnt <= '0;
                if (en && found) begin
                    sel   <= idx;
                    grant <= {{(K-1){1'b0}}, 1'b1} << idx;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    grant     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux32_rr_scheduler.sv
// tb_mux32_rr_scheduler: directed vector bench for the round-robin mux scheduler
module tb_mux32_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] req = '0;
    logic        out_ready = 1'b1;

    logic        v4, l4, b4, v1, l1, b1;
    logic [4:0]  s4, s1;
    logic [31:0] g4, g1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux32_rr_scheduler #(.K(32), .BURST(4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(v4), .sel(s4), .grant(g4), .last(l4), .busy(b4)
    );

    mux32_rr_scheduler #(.K(32), .BURST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
        .out_valid(v1), .sel(s1), .grant(g1), .last(l1), .busy(b1)
    );

    typedef struct {
        logic [31:0] req;
        logic        en;
        logic        rdy;
        logic        valid;
        logic [4:0]  sel;
        logic        last;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] onehot(input logic v, input logic [4:0] s);
        logic [31:0] one = 32'h1;
        return v ? (one << s) : 32'h0;
    endfunction

    initial begin
        int exp1[6];
        tbl[0]  = '{32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[1]  = '{32'h1,   1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[2]  = '{32'h1,   1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[3]  = '{32'h1,   1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[4]  = '{32'h1,   1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[5]  = '{32'h1,   1'b1, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[6]  = '{32'h1,   1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
        tbl[7]  = '{32'h0,   1'b1, 1'b1, 1'b1, 5'd0, 1'b1};
        tbl[8]  = '{32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[9]  = '{32'h20,  1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
        for (int i = 10; i < 16; i++) tbl[i] = '{32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1};
        tbl[16] = '{32'h0,   1'b1, 1'b1, 1'b1, 5'd5, 1'b1};
        tbl[17] = '{32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[18] = '{32'h180, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[19] = '{32'h180, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0};
        tbl[20] = '{32'h180, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1};
        tbl[21] = '{32'h180, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[22] = '{32'h180, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[23] = '{32'h180, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        tbl[24] = '{32'h180, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0};
        tbl[25] = '{32'h0,   1'b1, 1'b1, 1'b1, 5'd8, 1'b1};
        tbl[26] = '{32'h0,   1'b1, 1'b1, 1'b0, 5'd0, 1'b0};
        exp1 = '{0, 4, 31, 0, 4, 31};

        // Reset held for 5 cycles with no requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst%0d_valid", i), 32'(v4), 32'h0);
            chk($sformatf("rst%0d_sel", i), 32'(s4), 32'h0);
            chk($sformatf("rst%0d_grant", i), g4, 32'h0);
            chk($sformatf("rst%0d_busy", i), 32'(b4), 32'h0);
            chk($sformatf("rst%0d_valid1", i), 32'(v1), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Burst, stall, and enable-drop vectors on the BURST=4 instance.
        for (int i = 0; i < 27; i++) begin
            req = tbl[i].req;
            en = tbl[i].en;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(v4), 32'(tbl[i].valid));
            chk($sformatf("v%0d_busy", i), 32'(b4), 32'(tbl[i].valid));
            chk($sformatf("v%0d_last", i), 32'(l4), 32'(tbl[i].last));
            chk($sformatf("v%0d_grant", i), g4, onehot(tbl[i].valid, tbl[i].sel));
            if (tbl[i].valid) chk($sformatf("v%0d_sel", i), 32'(s4), 32'(tbl[i].sel));
            @(posedge clk);
            @(negedge clk);
        end

        // Async reset in the middle of a burst at sel=3.
        req = 32'h8;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("b3_%0d_sel", i), 32'(s4), 32'd3);
            chk($sformatf("b3_%0d_valid", i), 32'(v4), 32'h1);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(v4), 32'h0);
        chk("arst_grant", g4, 32'h0);
        chk("arst_last", 32'(l4), 32'h0);
        chk("arst_busy", 32'(b4), 32'h0);
        chk("arst_sel", 32'(s4), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req = 32'h8000_0011;
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", 32'(v4), 32'h0);

        // Pure per-beat round robin on the BURST=1 instance; ptr restarts at 0.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d_sel", i), 32'(s1), 32'(exp1[i]));
            chk($sformatf("rr%0d_valid", i), 32'(v1), 32'h1);
            chk($sformatf("rr%0d_grant", i), g1, onehot(1'b1, 5'(exp1[i])));
            chk($sformatf("rr%0d_last", i), 32'(l1), 32'h1);
            if (i == 0) chk("post_rst_sel4", 32'(s4), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
